// File: rtl/seed_pkg.sv
// Shared constants and state encoding for the seed RAM loader and reader.
package seed_pkg;
    localparam int SEED_W    = 3072;
    localparam int WORD_W    = 32;
    localparam int ADDR_W    = 7;
    localparam int NUM_WORDS = SEED_W / WORD_W;

    typedef enum logic [1:0] {
        FILL,
        CHECK,
        READY
    } state_e;
endpackage

// File: rtl/seed_ram_loader.sv
// Streams a checksummed seed into the seed RAM write port and publishes it
// to the reader via seed_valid until the reader acknowledges.
module seed_ram_loader
    import seed_pkg::*;
#(
    parameter int WORD_W    = seed_pkg::WORD_W,
    parameter int ADDR_W    = seed_pkg::ADDR_W,
    parameter int NUM_WORDS = seed_pkg::NUM_WORDS
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [WORD_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              seed_valid,
    input  logic              seed_ack,
    output logic              crc_err,
    output logic [15:0]       load_count
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]   chk_q, chk_d;
    logic [15:0]         load_count_q, load_count_d;
    logic                s_ready_q, s_ready_d;
    logic                ram_wren_q, ram_wren_d;
    logic [ADDR_W-1:0]   ram_wraddress_q, ram_wraddress_d;
    logic [WORD_W-1:0]   ram_data_q, ram_data_d;
    logic                seed_valid_q, seed_valid_d;
    logic                crc_err_q, crc_err_d;
    logic                hs;

    assign hs = s_valid & s_ready_q;

    always_comb begin
        state_d         = state_q;
        word_cnt_d      = word_cnt_q;
        chk_d           = chk_q;
        load_count_d    = load_count_q;
        ram_wren_d      = 1'b0;
        ram_wraddress_d = ram_wraddress_q;
        ram_data_d      = ram_data_q;
        seed_valid_d    = seed_valid_q;
        crc_err_d       = 1'b0;

        unique case (state_q)
            FILL: begin
                if (hs) begin
                    ram_wren_d      = 1'b1;
                    ram_wraddress_d = word_cnt_q;
                    ram_data_d      = s_data;
                    chk_d           = chk_q ^ s_data;
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = CHECK;
                    end else begin
                        word_cnt_d = word_cnt_q + ADDR_W'(1);
                    end
                end
            end
            CHECK: begin
                // Checksum word is consumed but never written to RAM.
                if (hs) begin
                    word_cnt_d = '0;
                    chk_d      = '0;
                    if (s_data == chk_q) begin
                        state_d      = READY;
                        seed_valid_d = 1'b1;
                        if (load_count_q != 16'hFFFF) begin
                            load_count_d = load_count_q + 16'd1;
                        end
                    end else begin
                        state_d   = FILL;
                        crc_err_d = 1'b1;
                    end
                end
            end
            READY: begin
                if (seed_ack) begin
                    state_d      = FILL;
                    seed_valid_d = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase

        // Ready tracks the next state so it never depends on s_valid.
        s_ready_d = (state_d != READY);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q         <= FILL;
            word_cnt_q      <= '0;
            chk_q           <= '0;
            load_count_q    <= '0;
            s_ready_q       <= 1'b0;
            ram_wren_q      <= 1'b0;
            ram_wraddress_q <= '0;
            ram_data_q      <= '0;
            seed_valid_q    <= 1'b0;
            crc_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_cnt_q      <= word_cnt_d;
            chk_q           <= chk_d;
            load_count_q    <= load_count_d;
            s_ready_q       <= s_ready_d;
            ram_wren_q      <= ram_wren_d;
            ram_wraddress_q <= ram_wraddress_d;
            ram_data_q      <= ram_data_d;
            seed_valid_q    <= seed_valid_d;
            crc_err_q       <= crc_err_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign ram_wren      = ram_wren_q;
    assign ram_wraddress = ram_wraddress_q;
    assign ram_data      = ram_data_q;
    assign seed_valid    = seed_valid_q;
    assign crc_err       = crc_err_q;
    assign load_count    = load_count_q;

endmodule

// File: tb/tb_seed_ram_loader.sv
// Directed/random bench for seed_ram_loader against a queue-based model of
// the expected RAM write sequence, checksum outcome and load counter.
module tb_seed_ram_loader;

    localparam int NW = 96;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [6:0]  ram_wraddress;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic        seed_valid;
    logic        seed_ack;
    logic        crc_err;
    logic [15:0] load_count;

    seed_ram_loader dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ram_wraddress (ram_wraddress),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .seed_valid    (seed_valid),
        .seed_ack      (seed_ack),
        .crc_err       (crc_err),
        .load_count    (load_count)
    );

    always #5 clk_in = ~clk_in;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_lc  = 0;
    logic [31:0] w [NW];
    logic [6:0]  wq_a [$];
    logic [31:0] wq_d [$];

    // Observed RAM write stream, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (ram_wren === 1'b1) begin
            wq_a.push_back(ram_wraddress);
            wq_d.push_back(ram_data);
        end
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one word and returns at posedge+1 after it has been accepted.
    task automatic send(input logic [31:0] d, input bit gaps);
        logic hs;
        int   budget;
        if (gaps) begin
            while ($urandom_range(1) == 0) begin
                s_valid = 1'b0;
                @(posedge clk_in); #1;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        budget  = 0;
        forever begin
            @(negedge clk_in);
            hs = s_ready;
            @(posedge clk_in); #1;
            if (hs === 1'b1) break;
            budget++;
            if (budget > 20) begin
                n_tests++;
                n_fail++;
                $display("FAIL handshake_timeout: observed s_ready=%b expected 1", s_ready);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] base, input bit bad,
                           input bit gaps, input int ack_at);
        logic [31:0] x;
        int          errs;
        wq_a.delete();
        wq_d.delete();
        x = '0;
        for (int i = 0; i < NW; i++) begin
            w[i] = base + 32'(i);
            x    = x ^ w[i];
        end
        for (int i = 0; i < NW; i++) begin
            if (i == ack_at) seed_ack = 1'b1;
            send(w[i], gaps);
            seed_ack = 1'b0;
        end
        send(bad ? (x ^ 32'd1) : x, gaps);
        if (!bad && exp_lc < 65535) exp_lc++;
        @(negedge clk_in);
        chk32({tag, ".seed_valid"}, 32'(seed_valid), 32'(!bad));
        chk32({tag, ".crc_err"},    32'(crc_err),    32'(bad));
        chk32({tag, ".s_ready"},    32'(s_ready),    32'(bad));
        chk32({tag, ".load_count"}, 32'(load_count), 32'(exp_lc));
        chk32({tag, ".n_writes"},   32'(wq_a.size()), 32'(NW));
        errs = 0;
        for (int i = 0; i < wq_a.size() && i < NW; i++) begin
            if (wq_a[i] !== 7'(i) || wq_d[i] !== w[i]) errs++;
        end
        chk32({tag, ".write_errs"}, 32'(errs), 32'd0);
        if (bad) begin
            @(negedge clk_in);
            chk32({tag, ".crc_err_1cyc"},  32'(crc_err),    32'd0);
            chk32({tag, ".seed_valid_lo"}, 32'(seed_valid), 32'd0);
        end
        @(posedge clk_in); #1;
    endtask

    // Holds a stale s_valid in READY, then acknowledges.
    task automatic do_ack(input string tag, input int stale_cycles);
        int nw0;
        nw0     = wq_a.size();
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        repeat (stale_cycles) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk32({tag, ".ready_hold_sv"}, 32'(seed_valid), 32'd1);
        chk32({tag, ".ready_hold_sr"}, 32'(s_ready),    32'd0);
        @(posedge clk_in); #1;
        seed_ack = 1'b1;
        @(posedge clk_in); #1;
        seed_ack = 1'b0;
        s_valid  = 1'b0;
        @(negedge clk_in);
        chk32({tag, ".seed_valid"}, 32'(seed_valid), 32'd0);
        chk32({tag, ".s_ready"},    32'(s_ready),    32'd1);
        chk32({tag, ".no_wr_ready"}, 32'(wq_a.size()), 32'(nw0));
        @(posedge clk_in); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        seed_ack = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk32("rst.s_ready",    32'(s_ready),       32'd0);
        chk32("rst.ram_wren",   32'(ram_wren),      32'd0);
        chk32("rst.wraddress",  32'(ram_wraddress), 32'd0);
        chk32("rst.ram_data",   ram_data,           32'd0);
        chk32("rst.seed_valid", 32'(seed_valid),    32'd0);
        chk32("rst.crc_err",    32'(crc_err),       32'd0);
        chk32("rst.load_count", 32'(load_count),    32'd0);
        rst = 1'b0;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk32("rst.s_ready_rise", 32'(s_ready), 32'd1);
        @(posedge clk_in); #1;

        do_load("bad",  32'hA5A5_0000, 1'b1, 1'b0, -1);
        do_load("good", 32'hA5A5_0000, 1'b0, 1'b0, -1);
        do_ack("ack1", 1);
        do_load("reload", 32'h0000_0000, 1'b0, 1'b0, -1);
        do_ack("ack2", 4);
        do_load("gaps", $urandom, 1'b0, 1'b1, 10);
        do_ack("ack3", 3);

        // Reset in the middle of a load, after word 40.
        for (int i = 0; i <= 40; i++) send(32'h1234_0000 + 32'(i), 1'b0);
        rst = 1'b1;
        @(posedge clk_in); #1;
        exp_lc = 0;
        @(negedge clk_in);
        chk32("midrst.s_ready",    32'(s_ready),       32'd0);
        chk32("midrst.ram_wren",   32'(ram_wren),      32'd0);
        chk32("midrst.wraddress",  32'(ram_wraddress), 32'd0);
        chk32("midrst.ram_data",   ram_data,           32'd0);
        chk32("midrst.seed_valid", 32'(seed_valid),    32'd0);
        chk32("midrst.load_count", 32'(load_count),    32'd0);
        rst = 1'b0;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk32("midrst.s_ready_rise", 32'(s_ready), 32'd1);
        @(posedge clk_in); #1;
        do_load("postrst", $urandom, 1'b0, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
